// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: instruction prefetch buffer between the tinyV fetch port
// and a synchronous instruction memory with a fixed 1-cycle read latency.
// Sequential word fetches run ahead of the core. Returned words are stored
// with their PCs in a DEPTH-entry FIFO, and a redirect flushes the buffer.
// Optional feature macro: PREFETCH_BYPASS_EN. When it is defined, a word
// returning into an empty buffer is offered to the core in the same cycle.
module ifetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rvalid,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [31:0]              instr_data,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [CW:0] DEPTH_EXT = (CW+1)'(DEPTH);

  logic          started_q, started_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pending_pc_q, pending_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];

  logic          fifo_valid;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic          has_space;
  logic [CW:0]   reserved;

  // A slot is reserved for the request still in flight, so a response is
  // always guaranteed room and never has to be dropped.
  assign reserved   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign has_space  = reserved < DEPTH_EXT;
  assign mem_req    = started_q && has_space && !redirect_valid;
  assign mem_addr   = fetch_pc_q;
  assign occupancy  = count_q;
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid && instr_ready && !redirect_valid;

`ifdef PREFETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = !fifo_valid && mem_rvalid && !redirect_valid;
  assign bypass_take = bypass_hit && instr_ready;
  assign instr_valid = fifo_valid || bypass_hit;
  assign instr_data  = bypass_hit ? mem_rdata    : data_q[rd_ptr_q];
  assign instr_pc    = bypass_hit ? pending_pc_q : pc_q[rd_ptr_q];
`else
  assign bypass_take = 1'b0;
  assign instr_valid = fifo_valid;
  assign instr_data  = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];
`endif

  // Data from an old path is never stored; a bypassed word is already consumed.
  assign push = mem_rvalid && !redirect_valid && !bypass_take;

  // Next-state logic: a redirect overrides issue, response and pop alike.
  always_comb begin
    started_d    = 1'b1;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    inflight_d   = inflight_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    data_d       = data_q;
    pc_d         = pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      inflight_d = mem_req;
      if (mem_req) begin
        fetch_pc_d   = fetch_pc_q + 32'd4;
        pending_pc_d = fetch_pc_q;
      end
      if (push) begin
        data_d[wr_ptr_q] = mem_rdata;
        pc_d[wr_ptr_q]   = pending_pc_q;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; an asserted reset wipes every stored and in-flight word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q    <= 1'b0;
      fetch_pc_q   <= RESET_PC & 32'hFFFF_FFFC;
      pending_pc_q <= '0;
      inflight_q   <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      started_q    <= started_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      data_q       <= data_d;
      pc_q         <= pc_d;
    end
  end

endmodule
